// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider with annul support.
// Result is {remainder, quotient}; divide-by-zero returns zero after two edges.
module div (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [33:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Magnitude of a two's-complement operand; 0x80000000 maps to itself.
    function automatic logic [31:0] f_abs(input logic signed [31:0] v, input logic en);
        logic signed [31:0] neg;
        neg = -v;
        return (en && v[31]) ? 32'(neg) : 32'(v);
    endfunction

    function automatic logic [31:0] f_neg_if(input logic signed [31:0] v, input logic en);
        logic signed [31:0] neg;
        neg = -v;
        return en ? 32'(neg) : 32'(v);
    endfunction

    // Partial remainder in [64:32] shifted left with the next dividend bit [31].
    assign w_diff = {r_work[64:32], r_work[31]} - {2'b00, r_divisor};
    assign w_quot = r_work[31:0];
    assign w_rem  = r_work[63:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            r_state <= S_BYZERO;
                        end else begin
                            r_state   <= S_ON;
                            r_cnt     <= 6'd0;
                            r_work    <= {33'd0, f_abs(opdata1_i, signed_div_i)};
                            r_divisor <= f_abs(opdata2_i, signed_div_i);
                            r_neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            r_neg_r   <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    r_state  <= S_END;
                    ready_o  <= 1'b1;
                    result_o <= 64'd0;
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else if (r_cnt != 6'd32) begin
                        // Negative difference: restore by shifting only, quotient bit 0.
                        if (w_diff[33]) begin
                            r_work <= {r_work[63:0], 1'b0};
                        end else begin
                            r_work <= {w_diff[32:0], r_work[30:0], 1'b1};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        result_o <= {f_neg_if(w_rem, r_neg_r), f_neg_if(w_quot, r_neg_q)};
                        ready_o  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_state  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    r_state  <= S_FREE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div block.
module tb_div;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_vec = 0;
    int n_err = 0;

    div u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full divide: operands are scrambled after edge 1 to show they are latched.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        opdata1_i    = ~a;
        opdata2_i    = 32'd0;
        signed_div_i = ~sgn;
        repeat (32) tick();
        check({tag, "/rdy@33"}, {63'd0, ready_o}, 64'd0);
        tick();
        check({tag, "/rdy@34"}, {63'd0, ready_o}, 64'd1);
        check({tag, "/res@34"}, result_o, exp);
        tick();
        check({tag, "/hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        start_i = 1'b0;
        tick();
        check({tag, "/clr"}, {ready_o, result_o[62:0]}, 64'd0);
    endtask

    task automatic do_div0(input string tag, input logic sgn, input logic [31:0] a);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = 32'd0;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        check({tag, "/rdy@1"}, {63'd0, ready_o}, 64'd0);
        tick();
        check({tag, "/rdy@2"}, {63'd0, ready_o}, 64'd1);
        check({tag, "/res@2"}, result_o, 64'd0);
        start_i = 1'b0;
        tick();
        check({tag, "/clr"}, {63'd0, ready_o}, 64'd0);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        check({tag, "/no_rdy"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        check("reset/rdy", {63'd0, ready_o}, 64'd0);
        check("reset/res", result_o, 64'd0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();

        do_div("u100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E);
        do_div("s-7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD);
        do_div("u-7_2",   1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC);
        do_div("s7_-2",   1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD);
        do_div("smin_-1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000);
        do_div("umax_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF);
        do_div0("u_by0", 1'b0, 32'd1234);
        do_div0("s_by0", 1'b1, 32'h80000000);

        // Annul mid-operation; start+annul together must not relaunch.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        repeat (8) tick();
        annul_i = 1'b1;
        tick();
        check("annul/@10", {ready_o, result_o[62:0]}, 64'd0);
        tick();
        check("annul/@11", {ready_o, result_o[62:0]}, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        watch_idle("annul", 40);
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Asynchronous reset at edge 20 of an operation.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        tick();
        repeat (19) tick();
        #2 reset_n = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst20/now", {ready_o, result_o[62:0]}, 64'd0);
        #1 reset_n = 1'b1;
        watch_idle("rst20", 40);
        do_div("u50_5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

        // Asynchronous reset while a result is held in END.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (34) tick();
        check("rstend/res", result_o, 64'h00000002_0000000E);
        #2 reset_n = 1'b0;
        #1;
        check("rstend/now", {ready_o, result_o[62:0]}, 64'd0);
        start_i = 1'b0;
        #1 reset_n = 1'b1;
        tick();
        do_div("s-100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
